// File: rtl/minutos_pkg.sv
// Shared definitions for the digital clock blocks (minutes and hours).
//   mode_e    : operating mode decoded from the front-panel switches
//   MIN_MAX   : highest minute value before wrap
//   SEG_TABLE : active-low 7-segment patterns {a,b,c,d,e,f,g}, indexed by digit 0..9
package minutos_pkg;

  typedef enum logic [1:0] {
    ModeRun,
    ModeSet,
    ModeHold
  } mode_e;

  localparam logic [5:0] MIN_MAX = 6'd59;

  // Entry [0] sits in the low bits, so SEG_TABLE[d] yields the pattern for digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational decimal digit to active-low 7-segment decoder.
//   i_digit : digit 0..9 (values above 9 blank the display)
//   o_seg   : segments {a,b,c,d,e,f,g}, active-low
module seg7_dec
  import minutos_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7f;
    if (i_digit <= 4'd9) begin
      o_seg = SEG_TABLE[i_digit];
    end
  end

endmodule

// File: rtl/minutos.sv
// Minute counter of the digital clock.
//   clock, reset      : system clock, asynchronous active-high reset
//   tick_in           : one-cycle strobe per second
//   UP, DOWN          : active-low asynchronous set buttons
//   SW15..SW17        : mode switches (SW15 belongs to the hours block)
//   clockOUT          : one-cycle minute carry on the 59->0 wrap in run mode
//   a..g / a1..g1     : registered active-low segments, units / tens digit
module minutos
  import minutos_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 60,
  parameter int unsigned INIT_MIN      = 0,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  input  logic UP,
  input  logic DOWN,
  input  logic SW15,
  input  logic SW16,
  input  logic SW17,
  output logic clockOUT,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic a1,
  output logic b1,
  output logic c1,
  output logic d1,
  output logic e1,
  output logic f1,
  output logic g1
);

  localparam logic [7:0]  TickLast     = 8'(TICKS_PER_MIN - 1);
  localparam logic [5:0]  InitMin      = 6'(INIT_MIN);
  localparam logic [31:0] RepLast      = 32'(REPEAT_CYCLES - 1);
  localparam logic [6:0]  InitSegUnits = SEG_TABLE[4'(INIT_MIN % 10)];
  localparam logic [6:0]  InitSegTens  = SEG_TABLE[4'(INIT_MIN / 10)];

  mode_e       r_mode, w_mode_d;
  logic [5:0]  r_min, w_min_d;
  logic [7:0]  r_presc, w_presc_d;
  logic        r_carry, w_carry_d;
  logic [31:0] r_rep_cnt, w_rep_d;

  logic r_up_meta, r_up_sync, r_up_prev;
  logic r_dn_meta, r_dn_sync, r_dn_prev;

  logic [6:0] r_seg_units, r_seg_tens;
  logic [6:0] w_seg_units, w_seg_tens;
  logic [3:0] w_units, w_tens;

  logic       w_up_held, w_dn_held, w_up_fall, w_dn_fall, w_one_held;
  logic       w_step_up, w_step_dn;
  logic [5:0] w_min_inc, w_min_dec;

  // SW15 is decoded by the hours block only.
  logic w_unused_sw15;
  assign w_unused_sw15 = SW15;

  // Mode FSM: switches are quasi-static and go straight into the next-state decode.
  always_comb begin
    w_mode_d = ModeHold;
    if (!SW16 && !SW17) begin
      w_mode_d = ModeRun;
    end else if (SW16 && SW17) begin
      w_mode_d = ModeSet;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode <= ModeRun;
    end else begin
      r_mode <= w_mode_d;
    end
  end

  // Two-flop button synchronisers plus one flop of history for press detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_up_meta <= 1'b1;
      r_up_sync <= 1'b1;
      r_up_prev <= 1'b1;
      r_dn_meta <= 1'b1;
      r_dn_sync <= 1'b1;
      r_dn_prev <= 1'b1;
    end else begin
      r_up_meta <= UP;
      r_up_sync <= r_up_meta;
      r_up_prev <= r_up_sync;
      r_dn_meta <= DOWN;
      r_dn_sync <= r_dn_meta;
      r_dn_prev <= r_dn_sync;
    end
  end

  assign w_up_held  = ~r_up_sync;
  assign w_dn_held  = ~r_dn_sync;
  assign w_up_fall  = r_up_prev & ~r_up_sync;
  assign w_dn_fall  = r_dn_prev & ~r_dn_sync;
  assign w_one_held = w_up_held ^ w_dn_held;

  // Press gives one step; holding a single button steps again every REPEAT_CYCLES cycles.
  // Both buttons down (or none) keeps the repeat counter at zero.
  always_comb begin
    w_rep_d   = '0;
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    if (r_mode == ModeSet && w_one_held) begin
      if (w_up_fall || w_dn_fall || r_rep_cnt == RepLast) begin
        w_step_up = w_up_held;
        w_step_dn = w_dn_held;
      end else begin
        w_rep_d = r_rep_cnt + 32'd1;
      end
    end
  end

  assign w_min_inc = (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
  assign w_min_dec = (r_min == 6'd0) ? MIN_MAX : r_min - 6'd1;

  always_comb begin
    w_min_d   = r_min;
    w_presc_d = r_presc;
    w_carry_d = 1'b0;
    case (r_mode)
      ModeRun: begin
        if (tick_in) begin
          if (r_presc == TickLast) begin
            w_presc_d = '0;
            w_min_d   = w_min_inc;
            w_carry_d = (r_min == MIN_MAX);
          end else begin
            w_presc_d = r_presc + 8'd1;
          end
        end
      end
      ModeSet: begin
        if (w_step_up) begin
          w_min_d = w_min_inc;
        end else if (w_step_dn) begin
          w_min_d = w_min_dec;
        end
        // Resume counts a full minute from the moment run mode returns.
        if (w_mode_d == ModeRun) begin
          w_presc_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min     <= InitMin;
      r_presc   <= '0;
      r_carry   <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_min     <= w_min_d;
      r_presc   <= w_presc_d;
      r_carry   <= w_carry_d;
      r_rep_cnt <= w_rep_d;
    end
  end

  assign w_units = 4'(r_min % 6'd10);
  assign w_tens  = 4'(r_min / 6'd10);

  seg7_dec u_dec_units (
    .i_digit (w_units),
    .o_seg   (w_seg_units)
  );

  seg7_dec u_dec_tens (
    .i_digit (w_tens),
    .o_seg   (w_seg_tens)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg_units <= InitSegUnits;
      r_seg_tens  <= InitSegTens;
    end else begin
      r_seg_units <= w_seg_units;
      r_seg_tens  <= w_seg_tens;
    end
  end

  assign clockOUT                  = r_carry;
  assign {a, b, c, d, e, f, g}     = r_seg_units;
  assign {a1, b1, c1, d1, e1, f1, g1} = r_seg_tens;

endmodule

// File: tb/tb_minutos.sv
module tb_minutos;

  logic clk, rst, tick, up, dn, sw15, sw16, sw17;
  logic carry;
  logic sa, sb, sc, sd, se, sf, sg;
  logic ta, tb, tc, td, te, tf, tg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_carry  = 0;

  minutos #(
    .TICKS_PER_MIN (2),
    .INIT_MIN      (0),
    .REPEAT_CYCLES (4)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .tick_in  (tick),
    .UP       (up),
    .DOWN     (dn),
    .SW15     (sw15),
    .SW16     (sw16),
    .SW17     (sw17),
    .clockOUT (carry),
    .a        (sa),
    .b        (sb),
    .c        (sc),
    .d        (sd),
    .e        (se),
    .f        (sf),
    .g        (sg),
    .a1       (ta),
    .b1       (tb),
    .c1       (tc),
    .d1       (td),
    .e1       (te),
    .f1       (tf),
    .g1       (tg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every carry pulse seen by the bench.
  always @(negedge clk) if (carry === 1'b1) n_carry++;

  function automatic logic [6:0] enc(input int dig);
    case (dig)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_min(input string tag, input int m);
    check_eq(tag, {18'd0, sa, sb, sc, sd, se, sf, sg, ta, tb, tc, td, te, tf, tg},
             {18'd0, enc(m % 10), enc(m / 10)});
  endtask

  // Short press: two synchronised-low cycles, one step, then settle.
  task automatic press(input bit is_up);
    if (is_up) up = 1'b0; else dn = 1'b0;
    repeat (2) @(negedge clk);
    up = 1'b1;
    dn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One tick; returns clockOUT right after the tick edge and one cycle later.
  task automatic do_tick(output logic c_at, output logic c_after);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    c_at = carry;
    @(negedge clk);
    c_after = carry;
  endtask

  logic c_at, c_after;
  int   exp_seq[4] = '{58, 59, 59, 0};

  initial begin
    rst = 1'b1; tick = 1'b0; up = 1'b1; dn = 1'b1;
    sw15 = 1'b0; sw16 = 1'b0; sw17 = 1'b0;
    repeat (3) @(negedge clk);
    check_min("reset_segs", 0);
    check_eq("reset_carry", 32'(carry), 0);
    rst = 1'b0;
    @(negedge clk);

    // Manual set with wrap in both directions.
    sw16 = 1'b1; sw17 = 1'b1;
    repeat (2) @(negedge clk);
    press(1'b0);
    check_min("set_down_wrap", 59);
    press(1'b1);
    check_min("set_up_wrap", 0);
    press(1'b0);
    press(1'b0);
    check_min("set_to_58", 58);
    check_eq("set_no_carry", 32'(n_carry), 0);

    // Run with two ticks per minute from 58.
    sw16 = 1'b0; sw17 = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_tick(c_at, c_after);
      check_eq($sformatf("run_carry_t%0d", i + 1), 32'(c_at), (i == 3) ? 1 : 0);
      check_min($sformatf("run_min_t%0d", i + 1), exp_seq[i]);
    end
    check_eq("run_carry_drop", 32'(c_after), 0);
    check_eq("run_carry_count", 32'(n_carry), 1);

    // Hold ignores ticks.
    sw16 = 1'b1; sw17 = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) do_tick(c_at, c_after);
    check_min("hold_frozen", 0);
    check_eq("hold_no_carry", 32'(n_carry), 1);

    // Auto-repeat: 13 synchronised-low cycles give press step + 3 repeats.
    sw16 = 1'b1; sw17 = 1'b1;
    repeat (2) @(negedge clk);
    up = 1'b0;
    repeat (4) @(negedge clk);
    check_min("rep_press_step", 1);
    repeat (3) @(negedge clk);
    check_min("rep_before_first", 1);
    @(negedge clk);
    check_min("rep_first", 2);
    repeat (5) @(negedge clk);
    up = 1'b1;
    repeat (6) @(negedge clk);
    check_min("rep_total", 4);

    up = 1'b0; dn = 1'b0;
    repeat (12) @(negedge clk);
    up = 1'b1; dn = 1'b1;
    repeat (5) @(negedge clk);
    check_min("both_no_change", 4);

    // Reset while a repeat is in progress.
    up = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    up = 1'b1;
    repeat (2) @(negedge clk);
    check_min("midrst_segs", 0);
    check_eq("midrst_carry", 32'(carry), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_min("midrst_no_step", 0);

    // Walk down to 48, then watch the one-cycle segment lag on 48 -> 47.
    for (int i = 0; i < 12; i++) press(1'b0);
    check_min("walk_48", 48);
    dn = 1'b0;
    repeat (3) @(negedge clk);
    check_min("seg_lag_old", 48);
    @(negedge clk);
    check_min("seg_lag_new", 47);
    dn = 1'b1;
    repeat (4) @(negedge clk);

    // Leaving set for run restarts the minute prescaler.
    sw16 = 1'b0; sw17 = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(c_at, c_after);
    check_min("pre_set_tick", 47);
    sw16 = 1'b1; sw17 = 1'b1;
    repeat (2) @(negedge clk);
    sw16 = 1'b0; sw17 = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(c_at, c_after);
    check_min("resume_no_early", 47);
    do_tick(c_at, c_after);
    check_min("resume_one_min", 48);
    check_eq("resume_no_carry", 32'(n_carry), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
